jtframe_pll_supervisor: RTL and testbench



---
 rtl/jtframe_pll_pkg.sv | 23 ++
 rtl/jtframe_pll_lock_sync.sv | 24 ++
 rtl/jtframe_pll_supervisor.sv | 152 +++++++++++++++
 tb/tb_jtframe_pll_supervisor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_pll_pkg.sv
// Shared types and helpers for the PLL supervisor: FSM state encoding and retry ceiling.
package jtframe_pll_pkg;

  typedef enum logic [2:0] {
    PLLRST  = 3'd0,
    WAIT    = 3'd1,
    STABLE  = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4
  } state_t;

  localparam int unsigned RETRY_MAX = 15;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/jtframe_pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the reference clock domain.
module jtframe_pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/jtframe_pll_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock with timeout and retry,
// then releases the downstream reset trees one at a time, re-arming on any loss of lock.
module jtframe_pll_supervisor
  import jtframe_pll_pkg::*;
#(
  parameter int RST_PULSE = 16,
  parameter int TIMEOUT   = 65536,
  parameter int LOCK_WAIT = 1024,
  parameter int NRST      = 3,
  parameter int STAGGER   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            locked,
  output logic            pll_rst,
  output logic [NRST-1:0] rst_out,
  output logic            ready,
  output logic            lost,
  output logic [3:0]      retries
);

  localparam int CMAX = max4(TIMEOUT, LOCK_WAIT, RST_PULSE, STAGGER);
  localparam int CW   = $clog2(CMAX);
  localparam int IW   = $clog2(NRST + 1);

  localparam logic [CW-1:0] PULSE_END = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] TO_END    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_END  = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] STAG_END  = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NRST - 1);
  localparam logic [3:0]    RETRY_SAT = 4'(RETRY_MAX);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              pll_rst_q, pll_rst_d;
  logic [NRST-1:0]   rst_out_q, rst_out_d;
  logic              ready_q, ready_d;
  logic              lost_q, lost_d;
  logic [3:0]        retries_q, retries_d;

  logic locked_s;
  logic rel_tick;
  logic rel_last;

  jtframe_pll_lock_sync u_lock_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (locked),
    .sync_o  (locked_s)
  );

  assign rel_tick = (cnt_q == STAG_END);
  assign rel_last = (idx_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PLLRST;
      cnt_q     <= '0;
      idx_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
      retries_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      lost_q    <= lost_d;
      retries_q <= retries_d;
    end
  end

  // Next state and shared counter; the counter restarts on every state change and on each release step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      PLLRST:  if (cnt_q == PULSE_END) state_d = WAIT;
      WAIT: begin
        if (locked_s)              state_d = STABLE;
        else if (cnt_q == TO_END)  state_d = PLLRST;
      end
      STABLE: begin
        if (!locked_s)               state_d = WAIT;
        else if (cnt_q == LOCK_END)  state_d = (NRST == 1) ? RUN : RELEASE;
      end
      RELEASE: begin
        if (!locked_s)                 state_d = PLLRST;
        else if (rel_tick && rel_last) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) state_d = PLLRST;
      end
      default: state_d = PLLRST;
    endcase
    if ((state_d != state_q) || (state_q == RELEASE && rel_tick)) cnt_d = '0;
  end

  // Registered outputs; loss of lock overrides any release due on the same edge.
  always_comb begin
    pll_rst_d = (state_d == PLLRST);
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    lost_d    = 1'b0;
    retries_d = retries_q;
    idx_d     = idx_q;
    case (state_q)
      WAIT: begin
        if (!locked_s && cnt_q == TO_END && retries_q != RETRY_SAT) retries_d = retries_q + 4'd1;
      end
      STABLE: begin
        if (locked_s && cnt_q == LOCK_END) begin
          rst_out_d = rst_out_q << 1;
          idx_d     = IW'(1);
          if (NRST == 1) ready_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          lost_d    = 1'b1;
        end else if (rel_tick) begin
          rst_out_d = rst_out_q << 1;
          idx_d     = idx_q + 1'b1;
          if (rel_last) ready_d = 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          lost_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pll_rst = pll_rst_q;
  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign lost    = lost_q;
  assign retries = retries_q;

endmodule

// File: tb/tb_jtframe_pll_supervisor.sv
// Scoreboard bench: stimulus queues every expected output change with its edge number;
// a negedge monitor pops an entry whenever a DUT output bundle changes and compares value and edge.
module tb_jtframe_pll_supervisor;

  typedef struct {
    int          cyc;
    logic [9:0]  val;
    string       name;
  } ev_t;

  logic clk;
  logic rst, locked, rst1, locked1;

  logic       pll_rst0, ready0, lost0;
  logic [2:0] rst_out0;
  logic [3:0] retries0;
  logic       pll_rst1, ready1, lost1;
  logic [0:0] rst_out1;
  logic [3:0] retries1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  ev_t q0[$];
  ev_t q1[$];
  ev_t e0v, e1v;
  logic [9:0] prev0 = 'x;
  logic [9:0] prev1 = 'x;
  logic [9:0] cur0, cur1;

  jtframe_pll_supervisor #(
    .RST_PULSE(4), .TIMEOUT(32), .LOCK_WAIT(16), .NRST(3), .STAGGER(4)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .pll_rst(pll_rst0), .rst_out(rst_out0),
    .ready(ready0), .lost(lost0), .retries(retries0)
  );

  jtframe_pll_supervisor #(
    .RST_PULSE(4), .TIMEOUT(32), .LOCK_WAIT(16), .NRST(1), .STAGGER(4)
  ) dut1 (
    .clk(clk), .rst(rst1), .locked(locked1), .pll_rst(pll_rst1), .rst_out(rst_out1),
    .ready(ready1), .lost(lost1), .retries(retries1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] o3(input logic p, input logic [2:0] r, input logic rd,
                                    input logic l, input logic [3:0] rt);
    return {p, r, rd, l, rt};
  endfunction

  function automatic logic [9:0] o1(input logic p, input logic r, input logic rd,
                                    input logic l, input logic [3:0] rt);
    return {2'b00, p, r, rd, l, rt};
  endfunction

  task automatic exp0(input int c, input logic [9:0] v, input string n);
    ev_t e;
    e.cyc = c; e.val = v; e.name = n;
    q0.push_back(e);
  endtask

  task automatic exp1(input int c, input logic [9:0] v, input string n);
    ev_t e;
    e.cyc = c; e.val = v; e.name = n;
    q1.push_back(e);
  endtask

  // Returns just after edge t, so inputs set now are first sampled by edge t+1.
  task automatic at(input int t);
    repeat (t - cyc) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cur0 = {pll_rst0, rst_out0, ready0, lost0, retries0};
    if (cur0 !== prev0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected edge=%0d got=%b required=no change", cyc, cur0);
      end else begin
        e0v = q0.pop_front();
        if (cur0 !== e0v.val || cyc != e0v.cyc) begin
          errors++;
          $display("FAIL %s got edge=%0d val=%b required edge=%0d val=%b",
                   e0v.name, cyc, cur0, e0v.cyc, e0v.val);
        end
      end
      prev0 = cur0;
    end
    cur1 = {2'b00, pll_rst1, rst_out1, ready1, lost1, retries1};
    if (cur1 !== prev1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected edge=%0d got=%b required=no change", cyc, cur1);
      end else begin
        e1v = q1.pop_front();
        if (cur1 !== e1v.val || cyc != e1v.cyc) begin
          errors++;
          $display("FAIL %s got edge=%0d val=%b required edge=%0d val=%b",
                   e1v.name, cyc, cur1, e1v.cyc, e1v.val);
        end
      end
      prev1 = cur1;
    end
  end

  initial begin
    rst = 1'b1; locked = 1'b0; rst1 = 1'b1; locked1 = 1'b0;
    exp0(1, o3(1, 3'b111, 0, 0, 0), "reset0");
    exp1(1, o1(1, 1'b1, 0, 0, 0), "reset1");

    // Lock present from reset release: WAIT reached at 7, STABLE at 8, releases 24/28/32.
    at(3); rst = 1'b0; locked = 1'b1;
    exp0(7,  o3(0, 3'b111, 0, 0, 0), "t1_pll_fall");
    exp0(24, o3(0, 3'b110, 0, 0, 0), "t1_rel0");
    exp0(28, o3(0, 3'b100, 0, 0, 0), "t1_rel1");
    exp0(32, o3(0, 3'b000, 1, 0, 0), "t1_rel2_ready");

    // Loss in RUN.
    at(40); locked = 1'b0;
    exp0(43, o3(1, 3'b111, 0, 1, 0), "run_loss");
    exp0(44, o3(1, 3'b111, 0, 0, 0), "run_lost_end");
    exp0(47, o3(0, 3'b111, 0, 0, 0), "run_pll_fall");

    // Loss seen on the very edge rst_out[1] would release.
    at(47); locked = 1'b1;
    exp0(66, o3(0, 3'b110, 0, 0, 0), "t5_rel0");
    at(67); locked = 1'b0;
    exp0(70, o3(1, 3'b111, 0, 1, 0), "t5_loss_wins");
    exp0(71, o3(1, 3'b111, 0, 0, 0), "t5_lost_end");
    exp0(74, o3(0, 3'b111, 0, 0, 0), "t5_pll_fall");

    // Loss mid-RELEASE between release steps.
    at(74); locked = 1'b1;
    exp0(93, o3(0, 3'b110, 0, 0, 0), "t4_rel0");
    at(93); locked = 1'b0;
    exp0(96,  o3(1, 3'b111, 0, 1, 0), "t4_loss");
    exp0(97,  o3(1, 3'b111, 0, 0, 0), "t4_lost_end");
    exp0(100, o3(0, 3'b111, 0, 0, 0), "t4_pll_fall");

    // One-cycle glitch in STABLE at cnt=10: back to WAIT, re-lock edge 113 gives STABLE at 115.
    at(100); locked = 1'b1;
    at(111); locked = 1'b0;
    at(112); locked = 1'b1;
    exp0(131, o3(0, 3'b110, 0, 0, 0), "t3_rel0");
    exp0(135, o3(0, 3'b100, 0, 0, 0), "t3_rel1");
    exp0(139, o3(0, 3'b000, 1, 0, 0), "t3_ready");

    // Lock held low: timeouts every 36 edges, retries saturating at 15.
    at(145); locked = 1'b0;
    exp0(148, o3(1, 3'b111, 0, 1, 0), "t2_loss");
    exp0(149, o3(1, 3'b111, 0, 0, 0), "t2_lost_end");
    exp0(152, o3(0, 3'b111, 0, 0, 0), "t2_pll_fall");
    for (int n = 1; n <= 17; n++) begin
      logic [3:0] r;
      r = (n > 15) ? 4'd15 : 4'(n);
      exp0(184 + 36 * (n - 1), o3(1, 3'b111, 0, 0, r), $sformatf("t2_timeout%0d", n));
      exp0(188 + 36 * (n - 1), o3(0, 3'b111, 0, 0, r), $sformatf("t2_repulse%0d", n));
    end

    // rst mid-RELEASE clears everything including retries.
    at(765); locked = 1'b1;
    exp0(784, o3(0, 3'b110, 0, 0, 15), "t6_rel0");
    at(786); rst = 1'b1;
    exp0(787, o3(1, 3'b111, 0, 0, 0), "t6_reset");
    at(788); rst = 1'b0;
    exp0(792, o3(0, 3'b111, 0, 0, 0), "t6_pll_fall");
    exp0(809, o3(0, 3'b110, 0, 0, 0), "t6_rel0b");
    exp0(813, o3(0, 3'b100, 0, 0, 0), "t6_rel1b");
    exp0(817, o3(0, 3'b000, 1, 0, 0), "t6_ready");

    // NRST=1: e0=837, rst_out[0] and ready change together at e0+18.
    at(830); rst1 = 1'b0;
    exp1(834, o1(0, 1'b1, 0, 0, 0), "n1_pll_fall");
    at(836); locked1 = 1'b1;
    exp1(855, o1(0, 1'b0, 1, 0, 0), "n1_release_ready");
    at(860); rst1 = 1'b1;
    exp1(861, o1(1, 1'b1, 0, 0, 0), "n1_reset");

    at(870);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL dut0_pending got=%0d outstanding first=%s required=0", q0.size(), q0[0].name);
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL dut1_pending got=%0d outstanding first=%s required=0", q1.size(), q1[0].name);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
